otter_cu_fsm_mw: RTL and testbench

Parametrised multi-cycle control unit for the OTTER RISC-V core, sitting between the instruction register and the datapath/memory/CSR blocks. It sequences fetch, execute, load writeback and trap entry. It adds four capabilities:
- configurable memory wait-states;
- a multi-source prioritised interrupt input with cause reporting;
- `mret` decode;
- an illegal-instruction trap path.

---
 rtl/otter_cu_pkg.sv | 29 ++
 rtl/irq_prio_enc.sv | 23 ++
 rtl/otter_cu_fsm_mw.sv | 182 ++++++++++++++++++
 tb/tb_otter_cu_fsm_mw.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_cu_pkg.sv
// Shared types and constants for the OTTER multi-cycle control unit.
package otter_cu_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    SYS    = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    INIT,
    FETCH,
    EXEC,
    LOAD_WAIT,
    WB,
    INTR,
    TRAP
  } state_type;

  localparam logic [11:0] MRET_F12 = 12'h302;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder; the lowest set request index wins.
module irq_prio_enc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Scan downwards so the last hit, the lowest index, is what remains.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = i[W-1:0];
      end
    end
  end

endmodule

// File: rtl/otter_cu_fsm_mw.sv
// OTTER multi-cycle control unit: fetch/execute/load sequencing with memory
// wait-states, prioritised interrupts, mret decode and illegal-instruction traps.
module otter_cu_fsm_mw
  import otter_cu_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = 4,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic [11:0]        func12,
  input  logic [NUM_IRQ-1:0] intr,
  input  logic               mie,
  output logic               pcWrite,
  output logic               regWrite,
  output logic               memWE2,
  output logic               memRDEN1,
  output logic               memRDEN2,
  output logic               reset,
  output logic               csr_WE,
  output logic               int_taken,
  output logic [CW-1:0]      int_cause,
  output logic               illegal,
  output logic               mret_exec
);

  localparam int unsigned    WW   = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [WW-1:0]  WMAX = WW'(MEM_WAIT);

  state_type         state_q, state_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [CW-1:0]     cause_q, cause_d;

  logic [NUM_IRQ-1:0] pend;
  logic               pend_valid;
  logic [CW-1:0]      pend_idx;
  logic               complete;
  logic               irq_ok;
  logic               lw_done;

  assign pend = intr & {NUM_IRQ{mie}};

  irq_prio_enc #(
    .N(NUM_IRQ),
    .W(CW)
  ) u_irq_prio_enc (
    .req  (pend),
    .valid(pend_valid),
    .idx  (pend_idx)
  );

  // EXEC already holds memRDEN2 for one cycle, so LOAD_WAIT needs MEM_WAIT more.
  assign lw_done = (MEM_WAIT == 0) || (wcnt_q == WMAX - WW'(1));

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    complete  = 1'b0;
    irq_ok    = 1'b0;
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    memWE2    = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    reset     = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    int_cause = '0;
    illegal   = 1'b0;
    mret_exec = 1'b0;

    case (state_q)
      INIT: begin
        reset   = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        memRDEN1 = 1'b1;
        if (wcnt_q == WMAX) state_d = EXEC;
      end
      EXEC: begin
        complete = 1'b1;
        irq_ok   = 1'b1;
        case (opcode)
          LUI, AUIPC, OP_IMM, OP_RG3, JAL, JALR: begin
            pcWrite  = 1'b1;
            regWrite = 1'b1;
          end
          BRANCH: pcWrite = 1'b1;
          STORE: begin
            pcWrite = 1'b1;
            memWE2  = 1'b1;
          end
          LOAD: begin
            memRDEN2 = 1'b1;
            complete = 1'b0;
            state_d  = (MEM_WAIT == 0) ? WB : LOAD_WAIT;
          end
          SYS: begin
            if (func3 != 3'd0) begin
              pcWrite  = 1'b1;
              regWrite = 1'b1;
              csr_WE   = 1'b1;
            end else if (func12 == MRET_F12) begin
              pcWrite   = 1'b1;
              mret_exec = 1'b1;
              irq_ok    = 1'b0;
            end else begin
              complete = 1'b0;
              state_d  = TRAP;
            end
          end
          default: begin
            complete = 1'b0;
            state_d  = TRAP;
          end
        endcase
      end
      LOAD_WAIT: begin
        memRDEN2 = 1'b1;
        if (lw_done) state_d = WB;
      end
      WB: begin
        pcWrite  = 1'b1;
        regWrite = 1'b1;
        complete = 1'b1;
        irq_ok   = 1'b1;
      end
      INTR: begin
        int_taken = 1'b1;
        pcWrite   = 1'b1;
        int_cause = cause_q;
        state_d   = FETCH;
      end
      TRAP: begin
        int_taken = 1'b1;
        illegal   = 1'b1;
        pcWrite   = 1'b1;
        state_d   = FETCH;
      end
      default: begin
        reset   = 1'b1;
        state_d = FETCH;
      end
    endcase

    if (complete) begin
      if (irq_ok && pend_valid) begin
        cause_d = pend_idx;
        state_d = INTR;
      end else begin
        state_d = FETCH;
      end
    end
  end

  always_comb begin
    if (state_d != state_q) begin
      wcnt_d = '0;
    end else if (wcnt_q != WMAX) begin
      wcnt_d = wcnt_q + WW'(1);
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= INIT;
      wcnt_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_otter_cu_fsm_mw.sv
// Bench for otter_cu_fsm_mw: one instance with MEM_WAIT=0, one with MEM_WAIT=2.
module tb_otter_cu_fsm_mw;

  // {pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE,
  //  int_taken, illegal, mret_exec, int_cause[1:0]}
  typedef struct packed {
    logic       pc;
    logic       rw;
    logic       we2;
    logic       rd1;
    logic       rd2;
    logic       rst;
    logic       csr;
    logic       it;
    logic       ill;
    logic       mret;
    logic [1:0] cause;
  } out_t;

  localparam out_t O_NONE  = 12'h000;
  localparam out_t O_RST   = 12'h040;
  localparam out_t O_FETCH = 12'h100;
  localparam out_t O_ALU   = 12'hC00;
  localparam out_t O_BR    = 12'h800;
  localparam out_t O_SW    = 12'hA00;
  localparam out_t O_LW    = 12'h080;
  localparam out_t O_WB    = 12'hC00;
  localparam out_t O_CSR   = 12'hC20;
  localparam out_t O_MRET  = 12'h804;
  localparam out_t O_TRAP  = 12'h818;
  localparam out_t O_INTR  = 12'h810;

  typedef struct {
    string       nm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [11:0] f12;
    logic [3:0]  irq;
    logic        mie;
    out_t        exec;
    bit          load;
    int          tail;   // 0 none, 1 interrupt, 2 trap
    logic [1:0]  cause;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic [6:0]  opc   [2];
  logic [2:0]  f3    [2];
  logic [11:0] f12   [2];
  logic [3:0]  irq   [2];
  logic        mie   [2];
  out_t        ov    [2];

  int n_checks = 0;
  int n_fail   = 0;
  out_t exp_q[$];
  vec_t tbl[12];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       pcw, rgw, we2, rd1, rd2, rst, csrw, itk, ill, mrx;
    logic [1:0] cause;
    otter_cu_fsm_mw #(
      .NUM_IRQ (4),
      .MEM_WAIT((g == 0) ? 0 : 2)
    ) dut (
      .clk      (clk),
      .RST_N    (rst_n[g]),
      .opcode   (opc[g]),
      .func3    (f3[g]),
      .func12   (f12[g]),
      .intr     (irq[g]),
      .mie      (mie[g]),
      .pcWrite  (pcw),
      .regWrite (rgw),
      .memWE2   (we2),
      .memRDEN1 (rd1),
      .memRDEN2 (rd2),
      .reset    (rst),
      .csr_WE   (csrw),
      .int_taken(itk),
      .int_cause(cause),
      .illegal  (ill),
      .mret_exec(mrx)
    );
    assign ov[g] = {pcw, rgw, we2, rd1, rd2, rst, csrw, itk, ill, mrx, cause};
  end

  task automatic chk(input string nm, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic set_in(input int k, input logic [6:0] op, input logic [2:0] fn3,
                        input logic [11:0] fn12, input logic [3:0] rq, input logic en);
    opc[k] = op;
    f3[k]  = fn3;
    f12[k] = fn12;
    irq[k] = rq;
    mie[k] = en;
  endtask

  // Called just after a rising edge; checks one expected entry per cycle.
  task automatic run_seq(input int k, input string nm);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", nm, i), ov[k], exp_q[i]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int k);
    rst_n[k] = 1'b0;
    #1;
    chk("reset_async", ov[k], O_RST);
    @(negedge clk);
    chk("reset_hold", ov[k], O_RST);
    #1 rst_n[k] = 1'b1;
    #1 chk("reset_init_cycle", ov[k], O_RST);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] p);
    logic [1:0] c = 2'd0;
    for (int i = 3; i >= 0; i--) if (p[i]) c = 2'(i);
    return c;
  endfunction

  // Reference: cycle-by-cycle output list for one instruction, from the rules.
  function automatic void model(input int mw, input logic [6:0] op, input logic [2:0] fn3,
                                input logic [11:0] fn12, input logic [3:0] rq, input logic en);
    out_t e;
    bit   ld = 0, il = 0, mr = 0;
    logic [3:0] p;
    exp_q.delete();
    for (int i = 0; i <= mw; i++) exp_q.push_back(O_FETCH);
    case (op)
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b1101111, 7'b1100111: e = O_ALU;
      7'b1100011: e = O_BR;
      7'b0100011: e = O_SW;
      7'b0000011: begin e = O_LW; ld = 1; end
      7'b1110011: begin
        if (fn3 != 3'd0) e = O_CSR;
        else if (fn12 == 12'h302) begin e = O_MRET; mr = 1; end
        else begin e = O_NONE; il = 1; end
      end
      default: begin e = O_NONE; il = 1; end
    endcase
    exp_q.push_back(e);
    if (ld) begin
      for (int i = 0; i < mw; i++) exp_q.push_back(O_LW);
      exp_q.push_back(O_WB);
    end
    p = rq & {4{en}};
    if (il) exp_q.push_back(O_TRAP);
    else if (!mr && p != 4'd0) exp_q.push_back(O_INTR | out_t'(lowest(p)));
  endfunction

  function automatic void from_vec(input int mw, input vec_t v);
    exp_q.delete();
    for (int i = 0; i <= mw; i++) exp_q.push_back(O_FETCH);
    exp_q.push_back(v.exec);
    if (v.load) begin
      for (int i = 0; i < mw; i++) exp_q.push_back(O_LW);
      exp_q.push_back(O_WB);
    end
    if (v.tail == 1) exp_q.push_back(O_INTR | out_t'(v.cause));
    if (v.tail == 2) exp_q.push_back(O_TRAP);
  endfunction

  task automatic random_phase(input int k, input int mw, input int n);
    logic [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                             7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
    logic [6:0]  op;
    logic [2:0]  fn3;
    logic [11:0] fn12;
    for (int t = 0; t < n; t++) begin
      int sel = $urandom_range(0, 11);
      op   = (sel < 10) ? ops[sel] : 7'($urandom);
      fn3  = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom);
      fn12 = ($urandom_range(0, 1) == 1) ? 12'h302 : 12'($urandom);
      set_in(k, op, fn3, fn12, 4'($urandom), 1'($urandom));
      model(mw, op, fn3, fn12, irq[k], mie[k]);
      run_seq(k, $sformatf("rand_mw%0d_%0d", mw, t));
    end
  endtask

  initial begin
    tbl[0]  = '{"addi",      7'b0010011, 3'd0, 12'h000, 4'b0000, 1'b0, O_ALU,  0, 0, 2'd0};
    tbl[1]  = '{"add_irq",   7'b0110011, 3'd0, 12'h000, 4'b1010, 1'b1, O_ALU,  0, 1, 2'd1};
    tbl[2]  = '{"add_nomie", 7'b0110011, 3'd0, 12'h000, 4'b1010, 1'b0, O_ALU,  0, 0, 2'd0};
    tbl[3]  = '{"illegal",   7'b0000000, 3'd0, 12'h000, 4'b0001, 1'b1, O_NONE, 0, 2, 2'd0};
    tbl[4]  = '{"csrrw",     7'b1110011, 3'd1, 12'h305, 4'b0000, 1'b1, O_CSR,  0, 0, 2'd0};
    tbl[5]  = '{"mret",      7'b1110011, 3'd0, 12'h302, 4'b1111, 1'b1, O_MRET, 0, 0, 2'd0};
    tbl[6]  = '{"ecall",     7'b1110011, 3'd0, 12'h000, 4'b0010, 1'b1, O_NONE, 0, 2, 2'd0};
    tbl[7]  = '{"sw_irq",    7'b0100011, 3'd2, 12'h000, 4'b0100, 1'b1, O_SW,   0, 1, 2'd2};
    tbl[8]  = '{"beq",       7'b1100011, 3'd0, 12'h000, 4'b0000, 1'b1, O_BR,   0, 0, 2'd0};
    tbl[9]  = '{"lw_irq",    7'b0000011, 3'd2, 12'h000, 4'b1000, 1'b1, O_LW,   1, 1, 2'd3};
    tbl[10] = '{"lui",       7'b0110111, 3'd0, 12'h000, 4'b0000, 1'b1, O_ALU,  0, 0, 2'd0};
    tbl[11] = '{"jal_irq",   7'b1101111, 3'd0, 12'h000, 4'b0110, 1'b1, O_ALU,  0, 1, 2'd1};

    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      set_in(k, 7'd0, 3'd0, 12'd0, 4'd0, 1'b0);
    end
    #2;
    chk("reset_outputs0", ov[0], O_RST);
    chk("reset_outputs2", ov[1], O_RST);

    // MEM_WAIT = 0
    do_reset(0);
    for (int i = 0; i < 12; i++) begin
      set_in(0, tbl[i].op, tbl[i].f3, tbl[i].f12, tbl[i].irq, tbl[i].mie);
      from_vec(0, tbl[i]);
      run_seq(0, tbl[i].nm);
    end
    random_phase(0, 0, 40);

    // MEM_WAIT = 2
    do_reset(1);
    set_in(1, 7'b0000011, 3'd2, 12'd0, 4'd0, 1'b0);
    exp_q = '{O_FETCH, O_FETCH, O_FETCH, O_LW, O_LW, O_LW, O_WB};
    run_seq(1, "lw_mw2");
    set_in(1, 7'b0010011, 3'd0, 12'd0, 4'b0001, 1'b1);
    exp_q = '{O_FETCH, O_FETCH, O_FETCH, O_ALU, O_INTR};
    run_seq(1, "addi_irq_mw2");

    // Reset dropped during LOAD_WAIT takes effect without a clock edge.
    set_in(1, 7'b0000011, 3'd2, 12'd0, 4'd0, 1'b0);
    exp_q = '{O_FETCH, O_FETCH, O_FETCH, O_LW, O_LW};
    run_seq(1, "lw_abort");
    #1 chk("lw_abort_wait", ov[1], O_LW);
    do_reset(1);
    set_in(1, 7'b0110011, 3'd0, 12'd0, 4'd0, 1'b0);
    exp_q = '{O_FETCH, O_FETCH, O_FETCH, O_ALU};
    run_seq(1, "after_abort");
    random_phase(1, 2, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
